string_checker: RTL and testbench
=================================

# string_checker

Consumer end of the byte-string ROM interface: drives the advance strobe `o_next`, samples the returned byte stream on `i_data`, and compares it against a compile-time expected string up to the NUL terminator. It reports pass/fail, the first mismatch position and a running pass count. It sits beside a string ROM as a self-test and bring-up checker, and leaves the ROM rewound to index 0 when finished.

## Interface
- `EXPECTED`, default `"Hello world"`: expected string, leftmost character first. Byte `pos` = `EXPECTED[(LEN-1-pos)*8 +: 8]`.
- `LEN`, default 11: number of characters in `EXPECTED` (1..126).
- `READ_LAT`, default 2: cycles from an `o_next` high cycle, or from the accepted `i_start` cycle, to a valid `i_data` (1..15).
- `i_clock`  in  1  sole clock; all logic is on its rising edge.
- `i_resetn`  in  1  synchronous reset, active-low.
- `i_start`  in  1  one-cycle request to run a check; ignored unless idle.
- `i_data`  in  8  byte from the source (the ROM's data output).
- `o_next`  out  1  one-cycle advance strobe to the source.
- `o_busy`  out  1  high from the accepted start until `o_done`.
- `o_done`  out  1  one-cycle pulse when the verdict is final.
- `o_pass`  out  1  verdict; valid with `o_done` and held until the next accepted start.
- `o_fail_idx`  out  7  character position of the first failure; 0 on pass.
- `o_pass_count`  out  16  saturating count of passing runs.

## Operation
- FSM states: IDLE, WAIT, CHECK, REWIND, DONE. Position counter `pos` is 7 bits. Wait counter is 4 bits.
- IDLE:
  - `i_start`=1 → WAIT with `pos`=0, wait counter=READ_LAT, `o_busy`=1, `o_pass`=0, `o_fail_idx`=0.
- WAIT:
  - Decrement the wait counter each cycle.
  - At 0, go to CHECK. `i_data` is sampled in that CHECK cycle.
- CHECK, evaluated in priority order:
  1. `i_data`==0 and `pos`==LEN → pass. Go to REWIND.
  2. `i_data`==0 and `pos`<LEN → fail (short string). `o_fail_idx`=`pos`. Go to REWIND.
  3. `pos`==LEN and `i_data`≠0 → fail (long string). `o_fail_idx`=LEN. Go to the failure path.
  4. `i_data`≠expected[`pos`] → fail. `o_fail_idx`=`pos`. Go to the failure path.
  5. Otherwise, `pos`+1, pulse `o_next`, go to WAIT.
- REWIND:
  - Pulse `o_next` while the source is presenting NUL; this returns the source to index 0.
  - Next state is DONE.
- DONE:
  - `o_done`=1 for one cycle. `o_pass` is driven to the verdict.
  - On pass, `o_pass_count` increments, saturating at 16'hFFFF.
  - Next state is IDLE. `o_busy` drops in the same cycle `o_done` is high.
- Failure path without drain: go straight to DONE. No rewind is performed, so the source is left mid-string.
- Priority: reset > FSM. `i_start` outside IDLE is ignored.

## Timing
- All outputs are registered.
- Reset values: `o_next`=0, `o_busy`=0, `o_done`=0, `o_pass`=0, `o_fail_idx`=0, `o_pass_count`=0. The FSM resets to IDLE.
- Reset asserted mid-run aborts immediately. No `o_done` is produced and the pass count is cleared.
- `o_next` is high in the cycle after a CHECK/REWIND decision. The byte it selects is sampled exactly READ_LAT cycles later.
- Per-character cost: READ_LAT+1 cycles.
- Cycles from the accepted `i_start` cycle to the `o_done` cycle:
  - Passing run: (LEN+1)·(READ_LAT+1)+2. For the defaults, 12·3+2 = 38.
  - Fail at position k, no drain: (k+1)·(READ_LAT+1)+1.
  - Short string at position k: (k+1)·(READ_LAT+1)+2.
- `i_start` is accepted in the IDLE cycle that immediately follows DONE.

## Configuration
- `STRING_CHECKER_DRAIN_EN` defined:
  - A content mismatch enters DRAIN instead of DONE.
  - DRAIN keeps pulsing `o_next` every READ_LAT+1 cycles and samples each byte, until `i_data`==0. It then goes to REWIND, so the source is always left at index 0.
  - DRAIN has a bound of 127 bytes. If no NUL is seen by then, go to DONE without rewind.
  - `o_fail_idx` keeps the first failing position.
- Not defined: no DRAIN state, and failures go straight to DONE.

## Test plan
- Source model with READ_LAT=2 holding "Hello world\0", one `i_start` → 12 `o_next` pulses. `o_done` arrives 38 cycles after start with `o_pass`=1, `o_fail_idx`=0, `o_pass_count`=1. The source ends at index 0.
- Source holding "Hellx world\0" → `o_pass`=0, `o_fail_idx`=4.
  - Drain on: the source ends at index 0.
  - Drain off: `o_done` arrives 16 cycles after start.
- Source holding "Hello\0" → `o_pass`=0, `o_fail_idx`=5. A rewind pulse is issued.
- Source holding "Hello worlds\0" → `o_pass`=0, `o_fail_idx`=11.
- Three back-to-back passing runs, with `i_start` pulsed while busy → extra starts are ignored and `o_pass_count`=3. Preload the count to 16'hFFFF, then pass once more → it stays 16'hFFFF.
- Drop `i_resetn` at character 6 → the next cycle shows all outputs 0 and the FSM in IDLE with no `o_done`. A new start then runs normally.

Source files
------------

// File: rtl/string_checker.sv
// string_checker: reads a NUL-terminated byte string from a ROM-style source and checks it against EXPECTED
//   Parameters:
//     LEN       number of characters in EXPECTED (1..126)
//     EXPECTED  expected string, leftmost character in the most significant byte
//     READ_LAT  cycles from an o_next pulse (or the accepted start) to valid i_data (1..15)
//   Ports:
//     i_clock       clock, rising edge
//     i_resetn      synchronous reset, active-low
//     i_start       one-cycle run request, only accepted while idle
//     i_data        byte returned by the source
//     o_next        one-cycle advance strobe to the source
//     o_busy        high from the accepted start until the o_done cycle
//     o_done        one-cycle pulse when the verdict is final
//     o_pass        verdict, held until the next accepted start
//     o_fail_idx    position of the first failing character, 0 on pass
//     o_pass_count  saturating count of passing runs
//   Build option: define STRING_CHECKER_DRAIN_EN to drain a failing string up to its NUL and
//   rewind the source, so the source is left at index 0 after a mismatch as well.
module string_checker #(
    parameter int               LEN      = 11,
    parameter logic [8*LEN-1:0] EXPECTED = "Hello world",
    parameter int               READ_LAT = 2
) (
    input  logic        i_clock,
    input  logic        i_resetn,
    input  logic        i_start,
    input  logic [7:0]  i_data,
    output logic        o_next,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_pass,
    output logic [6:0]  o_fail_idx,
    output logic [15:0] o_pass_count
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] WAIT   = 3'd1;
    localparam logic [2:0] CHECK  = 3'd2;
    localparam logic [2:0] REWIND = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;
`ifdef STRING_CHECKER_DRAIN_EN
    localparam logic [2:0] DRAIN    = 3'd5;
    localparam logic [2:0] FAIL_NXT = DRAIN;
`else
    localparam logic [2:0] FAIL_NXT = DONE;
`endif
    localparam logic [3:0] LAT  = 4'(READ_LAT);
    localparam logic [6:0] LEN7 = 7'(LEN);

    logic [2:0] state;
    logic [2:0] nxt;
    logic [6:0] pos;
    logic [3:0] wcnt;
    logic       verdict;
    logic       adv;
    logic       nul;
    logic       bad;
    logic       start;
    logic [7:0] exp_mem [128];
`ifdef STRING_CHECKER_DRAIN_EN
    logic [6:0] dcnt;
`endif

    // A full 128-entry table lets the 7-bit position index it directly, including pos == LEN.
    for (genvar g = 0; g < 128; g++) begin : g_exp
        if (g < LEN) begin : g_chr
            assign exp_mem[g] = EXPECTED[(LEN-1-g)*8 +: 8];
        end else begin : g_pad
            assign exp_mem[g] = 8'h00;
        end
    end

    assign nul   = i_data == 8'h00;
    assign bad   = pos == LEN7 || i_data != exp_mem[pos];
    assign start = state == IDLE && i_start;

    // adv marks a decision that advances the source; it becomes o_next one cycle later.
    always_comb begin
        nxt = state;
        adv = 1'b0;
        case (state)
            IDLE:   nxt = i_start ? WAIT : IDLE;
            WAIT:   nxt = (wcnt == 4'd1) ? CHECK : WAIT;
            CHECK: begin
                nxt = nul ? REWIND : bad ? FAIL_NXT : WAIT;
                adv = nxt != DONE;
            end
`ifdef STRING_CHECKER_DRAIN_EN
            DRAIN: begin
                if (wcnt == 4'd0) begin
                    nxt = nul ? REWIND : (dcnt == 7'd126) ? DONE : DRAIN;
                    adv = nxt != DONE;
                end
            end
`endif
            REWIND: nxt = DONE;
            DONE:   nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clock) begin
        if (!i_resetn) begin
            state        <= IDLE;
            pos          <= 7'd0;
            wcnt         <= 4'd0;
            verdict      <= 1'b0;
            o_next       <= 1'b0;
            o_busy       <= 1'b0;
            o_done       <= 1'b0;
            o_pass       <= 1'b0;
            o_fail_idx   <= 7'd0;
            o_pass_count <= 16'd0;
`ifdef STRING_CHECKER_DRAIN_EN
            dcnt         <= 7'd0;
`endif
        end else begin
            state  <= nxt;
            o_next <= adv;
            o_done <= nxt == DONE;
            o_busy <= nxt != IDLE && nxt != DONE;
            // Reload on every advance so the next sample lands exactly READ_LAT cycles after o_next.
            wcnt   <= (adv || state == IDLE) ? LAT : wcnt - {3'b000, wcnt != 4'd0};
            pos    <= (state == IDLE) ? 7'd0 : (state == CHECK && nxt == WAIT) ? pos + 7'd1 : pos;
`ifdef STRING_CHECKER_DRAIN_EN
            dcnt   <= (state == DRAIN) ? dcnt + {6'd0, wcnt == 4'd0} : 7'd0;
`endif
            if (start) begin
                verdict    <= 1'b0;
                o_pass     <= 1'b0;
                o_fail_idx <= 7'd0;
            end else begin
                if (state == CHECK && nul)
                    verdict <= pos == LEN7;
                // A NUL exactly at LEN is the pass case and leaves the index at 0.
                if (state == CHECK && (nul ? pos != LEN7 : bad))
                    o_fail_idx <= pos;
                if (nxt == DONE)
                    o_pass <= verdict;
            end
            if (nxt == DONE && verdict && o_pass_count != 16'hFFFF)
                o_pass_count <= o_pass_count + 16'd1;
        end
    end
endmodule

// File: tb/tb_string_checker.sv
// tb_string_checker: directed bench for string_checker against a READ_LAT=2 string ROM model
module tb_string_checker;
`ifdef STRING_CHECKER_DRAIN_EN
    localparam bit DRAIN_ON = 1'b1;
`else
    localparam bit DRAIN_ON = 1'b0;
`endif

    logic        i_clock = 1'b0;
    logic        i_resetn = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_data;
    logic        o_next;
    logic        o_busy;
    logic        o_done;
    logic        o_pass;
    logic [6:0]  o_fail_idx;
    logic [15:0] o_pass_count;

    int checks = 0;
    int failures = 0;
    int pulses;
    int cyc;
    logic [7:0] mem [16];
    logic [3:0] idx;
    logic       src_rst = 1'b0;

    string_checker dut (
        .i_clock(i_clock),
        .i_resetn(i_resetn),
        .i_start(i_start),
        .i_data(i_data),
        .o_next(o_next),
        .o_busy(o_busy),
        .o_done(o_done),
        .o_pass(o_pass),
        .o_fail_idx(o_fail_idx),
        .o_pass_count(o_pass_count)
    );

    always #5 i_clock = ~i_clock;

    // Source: index register plus one output register gives two cycles from o_next to data.
    // An advance while presenting NUL wraps back to index 0.
    always @(posedge i_clock) begin
        if (!i_resetn || src_rst) idx <= 4'd0;
        else if (o_next) idx <= (mem[idx] == 8'h00) ? 4'd0 : idx + 4'd1;
        i_data <= mem[idx];
    end

    task automatic set_src(input string s);
        for (int i = 0; i < 16; i++) mem[i] = (i < s.len()) ? s[i] : 8'h00;
        src_rst = 1'b1;
        @(posedge i_clock); #1;
        src_rst = 1'b0;
    endtask

    // One run: start in the next cycle, count cycles and o_next pulses until o_done.
    task automatic run(input bit poke);
        pulses = 0;
        cyc = 0;
        @(posedge i_clock); #1;
        i_start = 1'b1;
        while (cyc < 300) begin
            @(posedge i_clock); #1;
            cyc++;
            i_start = poke && (cyc == 10 || cyc == 30);
            pulses += int'(o_next);
            if (o_done) break;
        end
        i_start = 1'b0;
        checks++;
        if (o_done !== 1'b1) begin failures++; $display("FAIL run_timeout: o_done=%b after %0d cycles, required 1", o_done, cyc); end
    endtask

    task automatic apply_reset;
        i_resetn = 1'b0;
        i_start = 1'b0;
        repeat (3) @(posedge i_clock);
        #1;
        i_resetn = 1'b1;
    endtask

    task automatic test_reset;
        apply_reset();
        checks++;
        if ({o_next, o_busy, o_done, o_pass} !== 4'b0000) begin failures++; $display("FAIL reset_flags: next/busy/done/pass=%b required 0000", {o_next, o_busy, o_done, o_pass}); end
        checks++;
        if (o_fail_idx !== 7'd0) begin failures++; $display("FAIL reset_fail_idx: got %0d required 0", o_fail_idx); end
        checks++;
        if (o_pass_count !== 16'd0) begin failures++; $display("FAIL reset_pass_count: got %0d required 0", o_pass_count); end
    endtask

    task automatic test_pass;
        set_src("Hello world");
        run(1'b0);
        checks++;
        if (cyc != 38) begin failures++; $display("FAIL pass_latency: got %0d cycles required 38", cyc); end
        checks++;
        if (o_pass !== 1'b1) begin failures++; $display("FAIL pass_verdict: got %b required 1", o_pass); end
        checks++;
        if (o_fail_idx !== 7'd0) begin failures++; $display("FAIL pass_fail_idx: got %0d required 0", o_fail_idx); end
        checks++;
        if (o_pass_count !== 16'd1) begin failures++; $display("FAIL pass_count: got %0d required 1", o_pass_count); end
        checks++;
        if (pulses != 12) begin failures++; $display("FAIL pass_next_pulses: got %0d required 12", pulses); end
        checks++;
        if (idx !== 4'd0) begin failures++; $display("FAIL pass_src_index: got %0d required 0", idx); end
        checks++;
        if (o_busy !== 1'b0) begin failures++; $display("FAIL pass_busy_at_done: got %b required 0", o_busy); end
        @(posedge i_clock); #1;
        checks++;
        if ({o_done, o_pass} !== 2'b01) begin failures++; $display("FAIL pass_after_done: done/pass=%b required 01", {o_done, o_pass}); end
    endtask

    task automatic test_mismatch;
        set_src("Hellx world");
        run(1'b0);
        checks++;
        if (o_pass !== 1'b0) begin failures++; $display("FAIL mismatch_verdict: got %b required 0", o_pass); end
        checks++;
        if (o_fail_idx !== 7'd4) begin failures++; $display("FAIL mismatch_fail_idx: got %0d required 4", o_fail_idx); end
        checks++;
        if (cyc != (DRAIN_ON ? 38 : 16)) begin failures++; $display("FAIL mismatch_latency: got %0d required %0d", cyc, DRAIN_ON ? 38 : 16); end
        checks++;
        if (pulses != (DRAIN_ON ? 12 : 4)) begin failures++; $display("FAIL mismatch_next_pulses: got %0d required %0d", pulses, DRAIN_ON ? 12 : 4); end
        checks++;
        if (idx !== (DRAIN_ON ? 4'd0 : 4'd4)) begin failures++; $display("FAIL mismatch_src_index: got %0d required %0d", idx, DRAIN_ON ? 0 : 4); end
        checks++;
        if (o_pass_count !== 16'd1) begin failures++; $display("FAIL mismatch_pass_count: got %0d required 1", o_pass_count); end
    endtask

    task automatic test_short;
        set_src("Hello");
        run(1'b0);
        checks++;
        if ({o_pass, o_fail_idx} !== {1'b0, 7'd5}) begin failures++; $display("FAIL short_verdict: pass=%b idx=%0d required pass=0 idx=5", o_pass, o_fail_idx); end
        checks++;
        if (cyc != 20) begin failures++; $display("FAIL short_latency: got %0d required 20", cyc); end
        checks++;
        if (pulses != 6) begin failures++; $display("FAIL short_next_pulses: got %0d required 6", pulses); end
        checks++;
        if (idx !== 4'd0) begin failures++; $display("FAIL short_src_index: got %0d required 0", idx); end
    endtask

    task automatic test_long;
        set_src("Hello worlds");
        run(1'b0);
        checks++;
        if ({o_pass, o_fail_idx} !== {1'b0, 7'd11}) begin failures++; $display("FAIL long_verdict: pass=%b idx=%0d required pass=0 idx=11", o_pass, o_fail_idx); end
        checks++;
        if (cyc != (DRAIN_ON ? 41 : 37)) begin failures++; $display("FAIL long_latency: got %0d required %0d", cyc, DRAIN_ON ? 41 : 37); end
        checks++;
        if (idx !== (DRAIN_ON ? 4'd0 : 4'd11)) begin failures++; $display("FAIL long_src_index: got %0d required %0d", idx, DRAIN_ON ? 0 : 11); end
    endtask

    task automatic test_back_to_back;
        apply_reset();
        set_src("Hello world");
        for (int r = 1; r <= 3; r++) begin
            run(1'b1);
            checks++;
            if (cyc != 38) begin failures++; $display("FAIL b2b_latency run %0d: got %0d required 38", r, cyc); end
            checks++;
            if ({o_pass, o_pass_count} !== {1'b1, 16'(r)}) begin failures++; $display("FAIL b2b_count run %0d: pass=%b count=%0d required pass=1 count=%0d", r, o_pass, o_pass_count, r); end
        end
    endtask

    task automatic test_saturate;
        force dut.o_pass_count = 16'hFFFF;
        @(posedge i_clock); #1;
        release dut.o_pass_count;
        run(1'b0);
        checks++;
        if ({o_pass, o_pass_count} !== {1'b1, 16'hFFFF}) begin failures++; $display("FAIL saturate_count: pass=%b count=%h required pass=1 count=ffff", o_pass, o_pass_count); end
    endtask

    task automatic test_reset_mid;
        bit saw_done;
        set_src("Hello world");
        @(posedge i_clock); #1;
        i_start = 1'b1;
        for (int c = 1; c <= 20; c++) begin
            @(posedge i_clock); #1;
            i_start = 1'b0;
        end
        checks++;
        if (o_busy !== 1'b1) begin failures++; $display("FAIL midreset_busy_before: got %b required 1", o_busy); end
        i_resetn = 1'b0;
        @(posedge i_clock); #1;
        checks++;
        if ({o_next, o_busy, o_done, o_pass, o_fail_idx, o_pass_count} !== 27'd0) begin failures++; $display("FAIL midreset_outputs: next=%b busy=%b done=%b pass=%b idx=%0d count=%0d required all 0", o_next, o_busy, o_done, o_pass, o_fail_idx, o_pass_count); end
        checks++;
        if (dut.state !== 3'd0) begin failures++; $display("FAIL midreset_state: got %0d required 0", dut.state); end
        saw_done = 1'b0;
        repeat (4) begin
            @(posedge i_clock); #1;
            saw_done |= o_done;
        end
        i_resetn = 1'b1;
        repeat (40) begin
            @(posedge i_clock); #1;
            saw_done |= o_done;
        end
        checks++;
        if (saw_done) begin failures++; $display("FAIL midreset_no_done: got o_done=1 required no pulse"); end
        run(1'b0);
        checks++;
        if ({o_pass, o_pass_count, cyc} !== {1'b1, 16'd1, 32'd38}) begin failures++; $display("FAIL midreset_rerun: pass=%b count=%0d cycles=%0d required 1/1/38", o_pass, o_pass_count, cyc); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_mismatch();
        test_short();
        test_long();
        test_back_to_back();
        test_saturate();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
